// File: rtl/chess_pkg.sv
// chess_pkg: shared encodings for the chess board datapath.
//   - piece type, color, op and status codes
//   - square_t {row, col} and piece_t {type, color, moved}
//   - INIT_BOARD: the standard starting position, black on rows 0/1
package chess_pkg;

    localparam int unsigned PIECE_W = 5;
    localparam int unsigned SQ_W    = 6;

    // Piece type codes
    localparam logic [2:0] PT_EMPTY  = 3'b000;
    localparam logic [2:0] PT_PAWN   = 3'b001;
    localparam logic [2:0] PT_KNIGHT = 3'b010;
    localparam logic [2:0] PT_BISHOP = 3'b011;
    localparam logic [2:0] PT_ROOK   = 3'b100;
    localparam logic [2:0] PT_QUEEN  = 3'b101;
    localparam logic [2:0] PT_KING   = 3'b110;

    // Color codes
    localparam logic CLR_WHITE = 1'b0;
    localparam logic CLR_BLACK = 1'b1;

    typedef enum logic [1:0] {
        OP_MOVE        = 2'b00,
        OP_PLACE       = 2'b01,
        OP_CLEAR       = 2'b10,
        OP_RESET_BOARD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_CAPTURE   = 2'b01,
        ST_EMPTY_SRC = 2'b10,
        ST_ILLEGAL   = 2'b11
    } status_e;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } square_t;

    typedef struct packed {
        logic [2:0] ptype;
        logic       color;
        logic       moved;
    } piece_t;

    typedef logic [7:0][7:0][PIECE_W-1:0] board_t;

    // Rows listed col7..col0 so that index [row][col] lands correctly.
    localparam logic [39:0] ROW_BLACK_BACK = {
        {PT_ROOK,   CLR_BLACK, 1'b0}, {PT_KNIGHT, CLR_BLACK, 1'b0},
        {PT_BISHOP, CLR_BLACK, 1'b0}, {PT_KING,   CLR_BLACK, 1'b0},
        {PT_QUEEN,  CLR_BLACK, 1'b0}, {PT_BISHOP, CLR_BLACK, 1'b0},
        {PT_KNIGHT, CLR_BLACK, 1'b0}, {PT_ROOK,   CLR_BLACK, 1'b0}};
    localparam logic [39:0] ROW_WHITE_BACK = {
        {PT_ROOK,   CLR_WHITE, 1'b0}, {PT_KNIGHT, CLR_WHITE, 1'b0},
        {PT_BISHOP, CLR_WHITE, 1'b0}, {PT_KING,   CLR_WHITE, 1'b0},
        {PT_QUEEN,  CLR_WHITE, 1'b0}, {PT_BISHOP, CLR_WHITE, 1'b0},
        {PT_KNIGHT, CLR_WHITE, 1'b0}, {PT_ROOK,   CLR_WHITE, 1'b0}};
    localparam logic [39:0] ROW_BLACK_PAWN = {8{PT_PAWN, CLR_BLACK, 1'b0}};
    localparam logic [39:0] ROW_WHITE_PAWN = {8{PT_PAWN, CLR_WHITE, 1'b0}};

    localparam board_t INIT_BOARD = {
        ROW_WHITE_BACK, ROW_WHITE_PAWN,
        40'd0, 40'd0, 40'd0, 40'd0,
        ROW_BLACK_PAWN, ROW_BLACK_BACK};

endpackage

// File: rtl/vblank_sync.sv
// vblank_sync: brings the vgaclk-domain vblank into the clk domain.
//   clk, reset_b (sync, active low) ; vblank in ; vblank_s out (synchronized)
module vblank_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_b,
    input  logic vblank,
    output logic vblank_s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], vblank};
        end
    end

    assign vblank_s = chain[STAGES-1];

endmodule

// File: rtl/board_state.sv
// board_state: authoritative 8x8 chess board feeding the VGA renderer.
//   clk, reset_b       clock, synchronous active-low reset
//   vblank             vertical blanking from the video domain
//   req_*              edit/move request, valid/ready handshake
//   done, status       one-cycle completion pulse and its result code
//   move_count         number of successful operations
//   boardPos           registered board, entry = {type, color, moved}
// Board writes land only while vblank_s is high so a frame never shows a
// half-applied move.
module board_state
    import chess_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   vblank,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [5:0]             req_from,
    input  logic [5:0]             req_to,
    input  logic [3:0]             req_piece,
    output logic                   done,
    output logic [1:0]             status,
    output logic [CNT_W-1:0]       move_count,
    output logic [7:0][7:0][4:0]   boardPos
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_WAIT_BLANK = 3'd2,
        S_COMMIT     = 3'd3,
        S_DONE       = 3'd4
    } state_e;

    state_e     state;
    op_e        lat_op;
    square_t    lat_from;
    square_t    lat_to;
    logic [3:0] lat_piece;
    status_e    pend_status;
    logic       vblank_s;

    vblank_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset_b  (reset_b),
        .vblank   (vblank),
        .vblank_s (vblank_s)
    );

    // Occupancy lookup and rule check on the latched request
    logic [2:0] src_type;
    logic       src_color;
    logic [2:0] dst_type;
    logic       dst_color;
    status_e    chk_status;
    piece_t     mv_piece;

    always_comb begin
        src_type   = boardPos[lat_from.row][lat_from.col][4:2];
        src_color  = boardPos[lat_from.row][lat_from.col][1];
        dst_type   = boardPos[lat_to.row][lat_to.col][4:2];
        dst_color  = boardPos[lat_to.row][lat_to.col][1];
        chk_status = ST_OK;
        case (lat_op)
            OP_MOVE: begin
                if (lat_from == lat_to) begin
                    chk_status = ST_ILLEGAL;
                end else if (src_type == PT_EMPTY) begin
                    chk_status = ST_EMPTY_SRC;
                end else if (dst_type != PT_EMPTY && dst_color == src_color) begin
                    chk_status = ST_ILLEGAL;
                end else if (dst_type != PT_EMPTY) begin
                    chk_status = ST_CAPTURE;
                end
            end
            OP_PLACE: begin
                if (dst_type != PT_EMPTY) begin
                    chk_status = ST_CAPTURE;
                end
            end
            default: chk_status = ST_OK;
        endcase

        // Nonzero type in req_piece promotes; its color bit is ignored
        mv_piece.ptype = (lat_piece[3:1] != PT_EMPTY) ? lat_piece[3:1] : src_type;
        mv_piece.color = src_color;
        mv_piece.moved = 1'b1;
    end

    // Request FSM, board storage and counters
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            done        <= 1'b0;
            status      <= 2'b00;
            move_count  <= '0;
            boardPos    <= INIT_BOARD;
            lat_op      <= OP_MOVE;
            lat_from    <= '0;
            lat_to      <= '0;
            lat_piece   <= '0;
            pend_status <= ST_OK;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_op    <= op_e'(req_op);
                        lat_from  <= square_t'(req_from);
                        lat_to    <= square_t'(req_to);
                        lat_piece <= req_piece;
                        req_ready <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    pend_status <= chk_status;
                    if (chk_status == ST_EMPTY_SRC || chk_status == ST_ILLEGAL) begin
                        done   <= 1'b1;
                        status <= chk_status;
                        state  <= S_DONE;
                    end else begin
                        state <= S_WAIT_BLANK;
                    end
                end
                S_WAIT_BLANK: begin
                    if (vblank_s) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    case (lat_op)
                        OP_MOVE: begin
                            boardPos[lat_to.row][lat_to.col]     <= mv_piece;
                            boardPos[lat_from.row][lat_from.col] <= '0;
                        end
                        OP_PLACE: boardPos[lat_to.row][lat_to.col] <= {lat_piece, 1'b0};
                        OP_CLEAR: boardPos[lat_to.row][lat_to.col] <= '0;
                        default:  boardPos <= INIT_BOARD;
                    endcase
                    // Counter is updated alongside done so both are seen together
                    if (lat_op == OP_RESET_BOARD) begin
                        move_count <= '0;
                    end else begin
                        move_count <= move_count + CNT_W'(1);
                    end
                    done   <= 1'b1;
                    status <= pend_status;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_state.sv
// tb_board_state: directed scoreboard bench for board_state.
module tb_board_state;

    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 16;

    localparam logic [1:0] MOVE  = 2'b00;
    localparam logic [1:0] PLACE = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] RSTB  = 2'b11;

    logic                 clk = 1'b0;
    logic                 reset_b;
    logic                 vblank;
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [5:0]           req_from;
    logic [5:0]           req_to;
    logic [3:0]           req_piece;
    logic                 done;
    logic [1:0]           status;
    logic [CW-1:0]        move_count;
    logic [7:0][7:0][4:0] bp;

    always #5 clk = ~clk;

    board_state #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .vblank     (vblank),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_from   (req_from),
        .req_to     (req_to),
        .req_piece  (req_piece),
        .done       (done),
        .status     (status),
        .move_count (move_count),
        .boardPos   (bp)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   t_hs   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] sq(input int r, input int c);
        return {3'(r), 3'(c)};
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset_b === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("status", 32'(status), 32'(mon_e.st));
                check("move_count", 32'(move_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] from,
                         input logic [5:0] to, input logic [3:0] piece);
        bit got;
        got       = 1'b0;
        req_op    = op;
        req_from  = from;
        req_to    = to;
        req_piece = piece;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            t_hs      = cyc;
        end
    endtask

    // Latency in the T+k sense: done seen in the cycle ending at edge T+k
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t_hs + 1;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic set_vblank(input logic v);
        @(posedge clk);
        #1;
        vblank = v;
        repeat (SYNC + 2) @(posedge clk);
        #1;
    endtask

    int  lat;
    int  e0;
    bit  seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_b   = 1'b0;
        vblank    = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_from  = '0;
        req_to    = '0;
        req_piece = '0;
        repeat (5) @(posedge clk);
        #1;
        reset_b = 1'b1;
        @(negedge clk);
        check("rst_b00", 32'(bp[0][0]), 32'b10010);
        check("rst_b04", 32'(bp[0][4]), 32'b11010);
        check("rst_b13", 32'(bp[1][3]), 32'b00110);
        check("rst_b74", 32'(bp[7][4]), 32'b11000);
        check("rst_b64", 32'(bp[6][4]), 32'b00100);
        check("rst_b44", 32'(bp[4][4]), 32'b00000);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_status", 32'(status), 32'd0);

        // Plain pawn push with blanking already active
        set_vblank(1'b1);
        exp_q.push_back('{st: 2'b00, cnt: 16'd1});
        issue(MOVE, sq(6, 4), sq(4, 4), 4'b0000);
        wait_done(20, lat);
        check("move_latency", 32'(lat), 32'd4);
        check("move_ready_low", 32'(req_ready), 32'd0);
        check("move_b44", 32'(bp[4][4]), 32'b00101);
        check("move_b64", 32'(bp[6][4]), 32'b00000);
        @(negedge clk);
        check("ready_back", 32'(req_ready), 32'd1);

        // Commit must wait for blanking
        set_vblank(1'b0);
        exp_q.push_back('{st: 2'b00, cnt: 16'd2});
        issue(MOVE, sq(6, 3), sq(4, 3), 4'b0000);
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_done_active", 32'(seen), 32'd0);
        check("active_b43", 32'(bp[4][3]), 32'b00000);
        check("active_b63", 32'(bp[6][3]), 32'b00100);
        check("active_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        vblank = 1'b1;
        e0     = cyc;
        lat    = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - e0;
                break;
            end
        end
        check("blank_commit_bound", 32'(lat > 0 && lat <= int'(SYNC) + 2), 32'd1);
        check("blank_b43", 32'(bp[4][3]), 32'b00101);
        check("blank_b63", 32'(bp[6][3]), 32'b00000);

        // Error paths complete without blanking
        set_vblank(1'b0);
        exp_q.push_back('{st: 2'b10, cnt: 16'd2});
        issue(MOVE, sq(3, 3), sq(2, 3), 4'b0000);
        wait_done(20, lat);
        check("empty_latency", 32'(lat), 32'd2);
        check("empty_b23", 32'(bp[2][3]), 32'b00000);
        exp_q.push_back('{st: 2'b11, cnt: 16'd2});
        issue(MOVE, sq(7, 0), sq(6, 0), 4'b0000);
        wait_done(20, lat);
        check("own_b70", 32'(bp[7][0]), 32'b10000);
        check("own_b60", 32'(bp[6][0]), 32'b00100);
        exp_q.push_back('{st: 2'b11, cnt: 16'd2});
        issue(MOVE, sq(5, 5), sq(5, 5), 4'b0000);
        wait_done(20, lat);
        check("same_sq_latency", 32'(lat), 32'd2);

        // Overwrite by PLACE, then capture with promotion
        set_vblank(1'b1);
        exp_q.push_back('{st: 2'b01, cnt: 16'd3});
        issue(PLACE, sq(0, 0) | sq(1, 0), sq(1, 0), 4'b0010);
        wait_done(20, lat);
        check("place_b10", 32'(bp[1][0]), 32'b00100);
        exp_q.push_back('{st: 2'b01, cnt: 16'd4});
        issue(MOVE, sq(1, 0), sq(0, 1), 4'b1011);
        wait_done(20, lat);
        check("promo_b01", 32'(bp[0][1]), 32'b10101);
        check("promo_b10", 32'(bp[1][0]), 32'b00000);

        // CLEAR then RESET_BOARD (counter returns to zero)
        exp_q.push_back('{st: 2'b00, cnt: 16'd5});
        issue(CLEAR, sq(0, 0), sq(0, 0), 4'b0000);
        wait_done(20, lat);
        check("clear_b00", 32'(bp[0][0]), 32'b00000);
        exp_q.push_back('{st: 2'b00, cnt: 16'd0});
        issue(RSTB, sq(0, 0), sq(0, 0), 4'b0000);
        wait_done(20, lat);
        check("rstb_b00", 32'(bp[0][0]), 32'b10010);
        check("rstb_b01", 32'(bp[0][1]), 32'b01010);
        check("rstb_b44", 32'(bp[4][4]), 32'b00000);

        // Reset while a move waits for blanking
        exp_q.push_back('{st: 2'b00, cnt: 16'd1});
        issue(PLACE, sq(0, 0), sq(3, 3), 4'b1010);
        wait_done(20, lat);
        check("queen_b33", 32'(bp[3][3]), 32'b10100);
        set_vblank(1'b0);
        issue(MOVE, sq(6, 0), sq(5, 0), 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_b33", 32'(bp[3][3]), 32'b00000);
        check("mid_rst_b60", 32'(bp[6][0]), 32'b00100);
        check("mid_rst_count", 32'(move_count), 32'd0);
        vblank = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_b50", 32'(bp[5][0]), 32'b00000);
        check("mid_rst_done", 32'(done), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
